fwrisc_regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the fwrisc core. It is the generalised successor of the 2-read/1-write GPR file.
- Configurable data width, depth and read-port count.
- Optional hardwired-zero entry 0.
- Write-first bypass on the synchronous read path.
- A built-in clear sequencer zeroes every entry after reset or on request.

Sits between decode (read addresses) and writeback (write port).

---
 rtl/fwrisc_regfile_pkg.sv | 40 ++++
 rtl/fwrisc_regfile_rdport.sv | 68 ++++++
 rtl/fwrisc_regfile_mp.sv | 152 +++++++++++++++
 tb/tb_fwrisc_regfile_mp.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_regfile_pkg
// Purpose  : Shared types, default sizes and helpers for the multi-read-port
//            register file (fwrisc_regfile_mp and its read-port sub-module).
// Contents : rf_state_t   - clear-sequencer state encoding
//            c_DEF_*      - default width / depth / port-count constants
//            get_port()   - extract one lane from a packed multi-port vector
// Revision : 1.0 - initial release
// ============================================================================
package fwrisc_regfile_pkg;

    // Clear sequencer: CLEAR walks every entry writing zero, IDLE is normal use.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_t;

    localparam int c_DEF_DATA_WIDTH = 32;
    localparam int c_DEF_ADDR_WIDTH = 6;
    localparam int c_DEF_NUM_RD     = 2;

    // Widest packed vector get_port() accepts, and widest lane it returns.
    localparam int c_MAX_VEC_W  = 256;
    localparam int c_MAX_LANE_W = 64;

    // Returns lane idx (width bits, lane 0 in the LSBs) of vec, zero-extended.
    function automatic logic [c_MAX_LANE_W-1:0] get_port(
        input logic [c_MAX_VEC_W-1:0] vec,
        input int unsigned            idx,
        input int unsigned            width
    );
        logic [c_MAX_LANE_W-1:0] w_mask;
        // A shift of a full 64 yields 0, so the mask becomes all ones.
        w_mask = (c_MAX_LANE_W'(1) << width) - c_MAX_LANE_W'(1);
        return c_MAX_LANE_W'(vec >> (idx * width)) & w_mask;
    endfunction

endpackage : fwrisc_regfile_pkg
`default_nettype wire

// File: rtl/fwrisc_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_regfile_rdport
// Purpose  : One registered read port of the register file. Captures the read
//            address each edge and registers the selected data, applying the
//            write-port forward, the hardwired-zero entry and the busy blank.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            i_raddr          - read address for this port
//            i_mem_data       - current array contents at i_raddr
//            i_we/i_we_clr    - a write lands this edge / it is a clear write
//            i_waddr/i_wdata  - address and data of that write
//            i_force_zero     - register file is busy clearing next cycle
//            o_rdata          - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module fwrisc_regfile_rdport
    import fwrisc_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_we,
    input  logic                  i_we_clr,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_force_zero,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_next;
    logic                  w_hit;

    // Clear writes are always forwarded so the final clear edge can never leak
    // stale contents; user writes only forward when BYPASS is enabled.
    assign w_hit = i_we && (i_waddr == i_raddr) && ((BYPASS != 0) || i_we_clr);

    always_comb begin
        w_rdata_next = i_mem_data;
        if (w_hit) begin
            w_rdata_next = i_wdata;
        end
        if ((ZERO_REG != 0) && (i_raddr == '0)) begin
            w_rdata_next = '0;
        end
        if (i_force_zero) begin
            w_rdata_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata_next;
        end
    end

    assign o_rdata = r_rdata;

endmodule : fwrisc_regfile_rdport
`default_nettype wire

// File: rtl/fwrisc_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_regfile_mp
// Purpose  : Parametrised multi-read-port register file for the fwrisc core.
//            One write port, NUM_RD registered read ports, optional hardwired
//            zero entry, optional write-first forward and a clear sequencer
//            that zeroes the whole array after reset or on clear_req.
// Ports    : clock, reset  - clock, asynchronous active-high reset
//            raddr / rdata - packed read addresses / registered read data
//            waddr, wdata, wen - write port
//            clear_req     - request a full re-clear (ignored while busy)
//            busy          - clear sequence in progress
//            wr_drop       - one-cycle pulse: a write was discarded while busy
// Revision : 1.0 - initial release
// ============================================================================
module fwrisc_regfile_mp
    import fwrisc_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int NUM_RD     = c_DEF_NUM_RD,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         wen,
    input  logic                         clear_req,
    output logic                         busy,
    output logic                         wr_drop
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    rf_state_t             r_state;
    rf_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_next;
    logic                  r_wr_drop;

    // Storage has no reset; the clear sequencer initialises it.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_busy;
    logic                  w_usr_wr;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_wa;
    logic [DATA_WIDTH-1:0] w_wd;
    logic                  w_force_zero;

    assign w_busy = (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                // Last entry (all ones) is written on this edge.
                if (&r_clr_cnt) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            default: begin
                w_state_next   = ST_CLEAR;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write arbitration: the clear sequencer owns the port while busy.
    // A user write in the same cycle as clear_req still lands (state is
    // IDLE); the sequence then overwrites it.
    // ------------------------------------------------------------------
    assign w_usr_wr = wen && !w_busy && !((ZERO_REG != 0) && (waddr == '0));
    assign w_we     = w_busy || w_usr_wr;
    assign w_wa     = w_busy ? r_clr_cnt : waddr;
    assign w_wd     = w_busy ? '0 : wdata;

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= wen && w_busy;
        end
    end

    // Read data is blanked during every cycle in which busy will be high.
    assign w_force_zero = (w_state_next == ST_CLEAR);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;

        assign w_ra = ADDR_WIDTH'(get_port(c_MAX_VEC_W'(raddr), gi, ADDR_WIDTH));

        fwrisc_regfile_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_rdport (
            .clk          (clock),
            .rst          (reset),
            .i_raddr      (w_ra),
            .i_mem_data   (r_mem[w_ra]),
            .i_we         (w_we),
            .i_we_clr     (w_busy),
            .i_waddr      (w_wa),
            .i_wdata      (w_wd),
            .i_force_zero (w_force_zero),
            .o_rdata      (rdata[gi*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

endmodule : fwrisc_regfile_mp
`default_nettype wire

// File: tb/tb_fwrisc_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwrisc_regfile_mp
// Purpose  : Self-checking bench. Two instances share all inputs:
//            u_dut_a (BYPASS=1, ZERO_REG=1) and u_dut_b (BYPASS=0, ZERO_REG=0).
//            Expected read data for both is queued when a read is driven and
//            compared after the edge that produces it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwrisc_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NR    = 2;
    localparam int DEPTH = 64;

    logic           clock = 1'b0;
    logic           reset;
    logic [NR*AW-1:0] raddr;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           wen;
    logic           clear_req;
    logic [NR*DW-1:0] rd_a, rd_b;
    logic           busy_a, busy_b, drop_a, drop_b;

    typedef struct packed {
        logic [63:0] a;   // {port1, port0} expected from u_dut_a
        logic [63:0] b;   // {port1, port0} expected from u_dut_b
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    fwrisc_regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR),
                        .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rd_a),
        .waddr(waddr), .wdata(wdata), .wen(wen), .clear_req(clear_req),
        .busy(busy_a), .wr_drop(drop_a));

    fwrisc_regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR),
                        .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rd_b),
        .waddr(waddr), .wdata(wdata), .wen(wen), .clear_req(clear_req),
        .busy(busy_b), .wr_drop(drop_b));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; wen = 1'b0; clear_req = 1'b0;
        raddr = '0; waddr = '0; wdata = '0;
        #2;
        checks++;
        if ({busy_a, busy_b, drop_a, drop_b} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags got %b want 1100", {busy_a, busy_b, drop_a, drop_b});
        end
        checks++;
        if ({rd_a, rd_b} !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0", rd_a, rd_b);
        end
        step();
        reset = 1'b0;
        n = 0;
        while (n < 200) begin
            step(); n++;
            if (!busy_a) break;
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL reset_busy_len got %0d want %0d", n, DEPTH);
        end
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_b got %b want 0", busy_b);
        end
        for (int i = 0; i < DEPTH; i++) begin
            raddr = {6'(DEPTH - 1 - i), 6'(i)};
            q.push_back('{a: 64'h0, b: 64'h0});
            step();
            e = q.pop_front();
            checks++;
            if (rd_a !== e.a) begin
                errors++;
                $display("FAIL sweep_a[%0d] got %h want %h", i, rd_a, e.a);
            end
            checks++;
            if (rd_b !== e.b) begin
                errors++;
                $display("FAIL sweep_b[%0d] got %h want %h", i, rd_b, e.b);
            end
        end
    endtask

    task automatic test_write_read();
        wen = 1'b1; waddr = 6'd5; wdata = 32'hDEADBEEF;
        step();
        wen = 1'b0;
        checks++;
        if ({drop_a, drop_b} !== 2'b00) begin
            errors++;
            $display("FAIL wr_drop_idle got %b want 00", {drop_a, drop_b});
        end
        raddr = {6'd5, 6'd5};
        q.push_back('{a: {2{32'hDEADBEEF}}, b: {2{32'hDEADBEEF}}});
        step();
        e = q.pop_front();
        checks++;
        if (rd_a !== e.a) begin
            errors++;
            $display("FAIL wr_rd_a got %h want %h", rd_a, e.a);
        end
        checks++;
        if (rd_b !== e.b) begin
            errors++;
            $display("FAIL wr_rd_b got %h want %h", rd_b, e.b);
        end
    endtask

    task automatic test_bypass();
        wen = 1'b1; waddr = 6'd9; wdata = 32'hDEADBEEF;
        step();
        wdata = 32'h12345678; raddr = {6'd9, 6'd9};
        // Same-edge write: forwarded only on the BYPASS=1 instance.
        q.push_back('{a: {2{32'h12345678}}, b: {2{32'hDEADBEEF}}});
        step();
        wen = 1'b0;
        e = q.pop_front();
        checks++;
        if (rd_a !== e.a) begin
            errors++;
            $display("FAIL bypass_a got %h want %h", rd_a, e.a);
        end
        checks++;
        if (rd_b !== e.b) begin
            errors++;
            $display("FAIL nobypass_b got %h want %h", rd_b, e.b);
        end
        q.push_back('{a: {2{32'h12345678}}, b: {2{32'h12345678}}});
        step();
        e = q.pop_front();
        checks++;
        if ({rd_a, rd_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL after_bypass got %h %h want %h %h", rd_a, rd_b, e.a, e.b);
        end
    endtask

    task automatic test_zero_reg();
        wen = 1'b1; waddr = 6'd0; wdata = 32'hFFFFFFFF;
        step();
        wen = 1'b0;
        checks++;
        if ({drop_a, drop_b} !== 2'b00) begin
            errors++;
            $display("FAIL zero_wr_drop got %b want 00", {drop_a, drop_b});
        end
        raddr = {6'd0, 6'd0};
        q.push_back('{a: 64'h0, b: {2{32'hFFFFFFFF}}});
        step();
        e = q.pop_front();
        checks++;
        if (rd_a !== e.a) begin
            errors++;
            $display("FAIL zero_reg_a got %h want %h", rd_a, e.a);
        end
        checks++;
        if (rd_b !== e.b) begin
            errors++;
            $display("FAIL zero_reg_b got %h want %h", rd_b, e.b);
        end
    endtask

    task automatic test_clear_req();
        int n;
        wen = 1'b1; waddr = 6'd3; wdata = 32'h00000055;
        step();
        // clear_req with a simultaneous write to 7: write lands, clear wipes it.
        clear_req = 1'b1; waddr = 6'd7; wdata = 32'h00000077; raddr = {6'd3, 6'd3};
        q.push_back('{a: 64'h0, b: 64'h0});
        step();
        clear_req = 1'b0; waddr = 6'd3; wdata = 32'h0000AAAA;
        e = q.pop_front();
        checks++;
        if ({rd_a, rd_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL clr_blank got %h %h want 0", rd_a, rd_b);
        end
        checks++;
        if ({busy_a, busy_b, drop_a, drop_b} !== 4'b1100) begin
            errors++;
            $display("FAIL clr_start got %b want 1100", {busy_a, busy_b, drop_a, drop_b});
        end
        n = 0;
        step(); n++;
        wen = 1'b0;
        checks++;
        if ({drop_a, drop_b} !== 2'b11) begin
            errors++;
            $display("FAIL wr_drop_pulse got %b want 11", {drop_a, drop_b});
        end
        step(); n++;
        checks++;
        if ({drop_a, drop_b} !== 2'b00) begin
            errors++;
            $display("FAIL wr_drop_once got %b want 00", {drop_a, drop_b});
        end
        while (n < 200) begin
            clear_req = (n == 30);   // must not restart the sequence
            step(); n++;
            if (!busy_a) break;
        end
        clear_req = 1'b0;
        checks++;
        if (n !== DEPTH || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL clr_busy_len got %0d/%b want %0d/0", n, busy_b, DEPTH);
        end
        raddr = {6'd7, 6'd3};
        q.push_back('{a: 64'h0, b: 64'h0});
        step();
        e = q.pop_front();
        checks++;
        if ({rd_a, rd_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL clr_a3_a7 got %h %h want 0", rd_a, rd_b);
        end
        raddr = {6'd5, 6'd0};
        q.push_back('{a: 64'h0, b: 64'h0});
        step();
        e = q.pop_front();
        checks++;
        if ({rd_a, rd_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL clr_a5_a0 got %h %h want 0", rd_a, rd_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, prev;
        for (int i = 0; i < 8; i++) begin
            d    = 32'hC0DE0000 + 32'(i);
            prev = (i == 0) ? 32'h0 : 32'hC0DE0000 + 32'(i - 1);
            wen = 1'b1; waddr = 6'(20 + i); wdata = d;
            raddr = {6'(19 + i), 6'(20 + i)};
            q.push_back('{a: {prev, d}, b: {prev, 32'h0}});
            step();
            e = q.pop_front();
            checks++;
            if (rd_a !== e.a) begin
                errors++;
                $display("FAIL b2b_a[%0d] got %h want %h", i, rd_a, e.a);
            end
            checks++;
            if (rd_b !== e.b) begin
                errors++;
                $display("FAIL b2b_b[%0d] got %h want %h", i, rd_b, e.b);
            end
        end
        wen = 1'b0;
    endtask

    task automatic test_reset_midclear();
        int n;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (20) step();        // clear counter now at 20
        reset = 1'b1;
        #1;
        checks++;
        if ({busy_a, busy_b, rd_a, rd_b} !== {2'b11, 128'h0}) begin
            errors++;
            $display("FAIL midclr_reset got %b%b %h %h want 11 0", busy_a, busy_b, rd_a, rd_b);
        end
        step(); step();
        reset = 1'b0;
        n = 0;
        while (n < 200) begin
            step(); n++;
            if (!busy_a) break;
        end
        checks++;
        if (n !== DEPTH || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL midclr_busy_len got %0d/%b want %0d/0", n, busy_b, DEPTH);
        end
        raddr = {6'd20, 6'd9};
        q.push_back('{a: 64'h0, b: 64'h0});
        step();
        e = q.pop_front();
        checks++;
        if ({rd_a, rd_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL midclr_read got %h %h want 0", rd_a, rd_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear_req();
        test_back_to_back();
        test_reset_midclear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fwrisc_regfile_mp
`default_nettype wire
